// File: rtl/clk_gate_pkg.sv
// Shared types and parameter defaults for the domain clock-gate controller.
package clk_gate_pkg;

  typedef enum logic [1:0] {
    ST_ON   = 2'd0,
    ST_IDLE = 2'd1,
    ST_OFF  = 2'd2,
    ST_WAKE = 2'd3
  } state_t;

  localparam int unsigned IDLE_CYCLES_DEF = 16;
  localparam int unsigned WAKE_CYCLES_DEF = 2;

endpackage

// File: rtl/clk_gate_sat_ctr.sv
// Saturating up-counter: counts edges with inc=1 and holds at all-ones.
module clk_gate_sat_ctr #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Idle-driven power/clock-gate controller for one clock domain.
// Define CLK_GATE_CTRL_STATS_EN to build the gated-cycle statistics counter.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = IDLE_CYCLES_DEF,
  parameter int unsigned WAKE_CYCLES = WAKE_CYCLES_DEF
) (
  input  logic        free_clk,
  input  logic        reset_n,
  input  logic        activity,
  input  logic        wake_req,
  input  logic        test_override,
  output logic        pwr_en,
  output logic        gating_override,
  output logic        wake_ack,
  output logic        gated,
  output logic [31:0] gated_cycles,
  output state_t      state_dbg
);

  localparam logic [7:0] IDLE_LOAD = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0] WAKE_LOAD = 8'(WAKE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       ack_done;

  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_ON: begin
        if (!activity && !wake_req) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = IDLE_LOAD;
        end
      end
      ST_IDLE: begin
        // Work or a wake request wins over an expiring idle count.
        if (activity || wake_req) begin
          state_nxt = ST_ON;
        end else if (cnt == 8'd0) begin
          state_nxt = ST_OFF;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      ST_OFF: begin
        if (activity || wake_req) begin
          state_nxt = ST_WAKE;
          cnt_nxt   = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (cnt == 8'd0) begin
          state_nxt = ST_ON;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: state_nxt = ST_ON;
    endcase
  end

  // Handshake: wake_req is a level held by the requester; wake_ack is a
  // single-cycle grant once the domain is ON, re-armed only after wake_req drops.
  always_ff @(posedge free_clk) begin
    if (!reset_n) begin
      state           <= ST_ON;
      cnt             <= 8'd0;
      pwr_en          <= 1'b1;
      gating_override <= 1'b0;
      wake_ack        <= 1'b0;
      gated           <= 1'b0;
      ack_done        <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      pwr_en          <= (state_nxt != ST_OFF);
      gated           <= (state_nxt == ST_OFF);
      gating_override <= test_override;
      wake_ack        <= 1'b0;
      if (!wake_req) begin
        ack_done <= 1'b0;
      end else if ((state == ST_ON) && !ack_done) begin
        wake_ack <= 1'b1;
        ack_done <= 1'b1;
      end
    end
  end

`ifdef CLK_GATE_CTRL_STATS_EN
  clk_gate_sat_ctr #(
    .WIDTH(32)
  ) u_stats (
    .clk    (free_clk),
    .reset_n(reset_n),
    .inc    (state == ST_OFF),
    .count  (gated_cycles)
  );
`else
  assign gated_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed table-driven bench for clk_gate_ctrl (IDLE_CYCLES=16, WAKE_CYCLES=2).
module tb_clk_gate_ctrl;
  import clk_gate_pkg::*;

`ifdef CLK_GATE_CTRL_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, activity, wake_req, test_override;
  logic        pwr_en, gating_override, wake_ack, gated;
  logic [31:0] gated_cycles;
  state_t      state_dbg;

  logic       sat_rst_n, sat_inc;
  logic [3:0] sat_count;

  clk_gate_ctrl #(.IDLE_CYCLES(16), .WAKE_CYCLES(2)) dut (
    .free_clk       (clk),
    .reset_n        (reset_n),
    .activity       (activity),
    .wake_req       (wake_req),
    .test_override  (test_override),
    .pwr_en         (pwr_en),
    .gating_override(gating_override),
    .wake_ack       (wake_ack),
    .gated          (gated),
    .gated_cycles   (gated_cycles),
    .state_dbg      (state_dbg)
  );

  clk_gate_sat_ctr #(.WIDTH(4)) u_sat (
    .clk    (clk),
    .reset_n(sat_rst_n),
    .inc    (sat_inc),
    .count  (sat_count)
  );

  // vector table
  typedef struct {
    int          reps;
    logic        rst_n, act, wreq, tovr;
    logic        pwr, gtd, ack, ovr;
    state_t      st;
    logic [31:0] gc;
  } vec_t;

  vec_t vecs[40];
  int   nv = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic add(input int reps, input logic rst_n, act, wreq, tovr,
                     input logic pwr, gtd, ack, ovr, input state_t st,
                     input logic [31:0] gc);
    vecs[nv] = '{reps, rst_n, act, wreq, tovr, pwr, gtd, ack, ovr, st, gc};
    nv++;
  endtask

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act_v,
                       input logic [31:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
    end
  endtask

  initial begin
    reset_n = 1'b0; activity = 1'b0; wake_req = 1'b0; test_override = 1'b0;
    sat_rst_n = 1'b0; sat_inc = 1'b0;

    //  reps rst act wrq tov | pwr gtd ack ovr state    gc(stats build)
    add(2,   0, 0, 0, 0,  1, 0, 0, 0, ST_ON,   0);    // reset
    add(2,   1, 1, 0, 0,  1, 0, 0, 0, ST_ON,   0);
    add(16,  1, 0, 0, 0,  1, 0, 0, 0, ST_IDLE, 0);    // idle countdown
    add(1,   1, 0, 0, 0,  0, 1, 0, 0, ST_OFF,  0);    // edge 17 gates
    add(100, 1, 0, 0, 0,  0, 1, 0, 0, ST_OFF,  100);
    add(1,   1, 0, 1, 0,  1, 0, 0, 0, ST_WAKE, 101);  // edge k
    add(1,   1, 0, 1, 0,  1, 0, 0, 0, ST_WAKE, 101);
    add(1,   1, 0, 1, 0,  1, 0, 0, 0, ST_ON,   101);
    add(1,   1, 0, 1, 0,  1, 0, 1, 0, ST_ON,   101);  // ack at k+3
    add(1,   1, 0, 1, 0,  1, 0, 0, 0, ST_ON,   101);  // no re-pulse
    add(1,   1, 0, 0, 0,  1, 0, 0, 0, ST_IDLE, 101);
    add(1,   1, 0, 1, 0,  1, 0, 0, 0, ST_ON,   101);
    add(1,   1, 0, 1, 0,  1, 0, 1, 0, ST_ON,   101);  // re-armed pulse
    add(10,  1, 0, 0, 0,  1, 0, 0, 0, ST_IDLE, 101);
    add(1,   1, 1, 0, 0,  1, 0, 0, 0, ST_ON,   101);  // abort
    add(16,  1, 0, 0, 0,  1, 0, 0, 0, ST_IDLE, 101);  // full reload
    add(1,   1, 0, 0, 0,  0, 1, 0, 0, ST_OFF,  101);
    add(1,   1, 1, 0, 0,  1, 0, 0, 0, ST_WAKE, 102);
    add(1,   1, 0, 0, 0,  1, 0, 0, 0, ST_WAKE, 102);
    add(1,   1, 0, 0, 0,  1, 0, 0, 0, ST_ON,   102);
    add(16,  1, 0, 0, 1,  1, 0, 0, 1, ST_IDLE, 102);  // override, FSM unchanged
    add(1,   1, 1, 0, 0,  1, 0, 0, 0, ST_ON,   102);  // act on cnt==0
    add(16,  1, 0, 0, 0,  1, 0, 0, 0, ST_IDLE, 102);
    add(1,   1, 0, 0, 0,  0, 1, 0, 0, ST_OFF,  102);
    add(1,   1, 0, 1, 0,  1, 0, 0, 0, ST_WAKE, 103);
    add(1,   0, 0, 1, 0,  1, 0, 0, 0, ST_ON,   0);    // reset mid-WAKE
    add(1,   1, 0, 1, 0,  1, 0, 1, 0, ST_ON,   0);
    add(16,  1, 0, 0, 0,  1, 0, 0, 0, ST_IDLE, 0);
    add(1,   1, 0, 0, 0,  0, 1, 0, 0, ST_OFF,  0);
    add(3,   1, 0, 0, 1,  0, 1, 0, 1, ST_OFF,  3);
    add(1,   0, 0, 0, 0,  1, 0, 0, 0, ST_ON,   0);    // reset in OFF

    for (int i = 0; i < nv; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        reset_n       = vecs[i].rst_n;
        activity      = vecs[i].act;
        wake_req      = vecs[i].wreq;
        test_override = vecs[i].tovr;
        @(posedge clk);
        #1;
        check($sformatf("v%0d.%0d pwr_en", i, r), 32'(pwr_en), 32'(vecs[i].pwr));
        check($sformatf("v%0d.%0d gated", i, r), 32'(gated), 32'(vecs[i].gtd));
        check($sformatf("v%0d.%0d wake_ack", i, r), 32'(wake_ack), 32'(vecs[i].ack));
        check($sformatf("v%0d.%0d gating_override", i, r), 32'(gating_override),
              32'(vecs[i].ovr));
        check($sformatf("v%0d.%0d state", i, r), 32'(state_dbg), 32'(vecs[i].st));
        if (r == vecs[i].reps - 1)
          check($sformatf("v%0d gated_cycles", i), gated_cycles,
                STATS_ON ? vecs[i].gc : 32'd0);
      end
    end

    // saturation corner on a narrow counter instance
    @(posedge clk); #1;
    check("sat reset", 32'(sat_count), 32'd0);
    sat_rst_n = 1'b1;
    sat_inc   = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk);
    end
    #1;
    check("sat count 14", 32'(sat_count), 32'd14);
    @(posedge clk); #1;
    check("sat reach max", 32'(sat_count), 32'd15);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
    end
    #1;
    check("sat hold max", 32'(sat_count), 32'd15);
    sat_inc = 1'b0;
    @(posedge clk); #1;
    check("sat idle hold", 32'(sat_count), 32'd15);
    sat_rst_n = 1'b0;
    @(posedge clk); #1;
    check("sat re-reset", 32'(sat_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
